// File: rtl/exe_operand_issue.sv
`default_nettype none
// ============================================================================
//  Module   : exe_operand_issue
//  Purpose  : ID->EX operand issue with EX/MEM/WB forwarding, load-use stall
//             detection and flush squashing.
//  Revision : 1.0  initial release
// ============================================================================
module exe_operand_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_sel_npc,
  input  logic        id_sel_imm,
  input  logic        id_wr_en,
  input  logic [4:0]  id_wr_addr,
  input  logic        id_is_load,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic [31:0] alu_output,
  input  logic [31:0] mem_fwd_data,
  input  logic [31:0] wb_fwd_data,
  input  logic        flush,
  output logic [31:0] output_data_1,
  output logic [31:0] output_data_2,
  output logic        mux_sel1,
  output logic        mux_sel2,
  output logic        ex_valid,
  output logic        stall
);

  typedef struct packed {
    logic       valid;
    logic       wr_en;
    logic [4:0] addr;
    logic       is_load;
  } tag_t;

  localparam tag_t c_bubble = '0;

  tag_t        r_ex_tag;
  tag_t        r_mem_tag;
  tag_t        r_wb_tag;

  logic        w_issue;
  logic        w_ex_wr_live;
  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;

  // Register 0 never matches, so it always falls through to the register file.
  function automatic logic tag_hit(input tag_t t, input logic [4:0] src);
    return t.valid & t.wr_en & (t.addr == src) & (t.addr != 5'd0);
  endfunction

  function automatic logic [31:0] pick(input logic [4:0] src, input logic [31:0] rf,
                                       input tag_t ex_t, input tag_t mem_t, input tag_t wb_t,
                                       input logic [31:0] ex_d, input logic [31:0] mem_d,
                                       input logic [31:0] wb_d);
    if (tag_hit(ex_t, src) && !ex_t.is_load) return ex_d;
    else if (tag_hit(mem_t, src))            return mem_d;
    else if (tag_hit(wb_t, src))             return wb_d;
    else                                     return rf;
  endfunction

  always_comb begin
    w_ex_wr_live = r_ex_tag.valid & r_ex_tag.is_load & r_ex_tag.wr_en & (r_ex_tag.addr != 5'd0);
    stall = id_valid & ~flush & w_ex_wr_live &
            ((id_use_rs & (id_rs == r_ex_tag.addr)) | (id_use_rt & (id_rt == r_ex_tag.addr)));
    w_issue  = id_valid & ~stall & ~flush;
    w_fwd_rs = pick(id_rs, rf_rdata1, r_ex_tag, r_mem_tag, r_wb_tag,
                    alu_output, mem_fwd_data, wb_fwd_data);
    w_fwd_rt = pick(id_rt, rf_rdata2, r_ex_tag, r_mem_tag, r_wb_tag,
                    alu_output, mem_fwd_data, wb_fwd_data);
  end

  // Tag pipeline advances unconditionally; a stalled or squashed slot enters as a bubble.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_ex_tag      <= c_bubble;
      r_mem_tag     <= c_bubble;
      r_wb_tag      <= c_bubble;
      output_data_1 <= 32'd0;
      output_data_2 <= 32'd0;
      mux_sel1      <= 1'b0;
      mux_sel2      <= 1'b0;
      ex_valid      <= 1'b0;
    end else begin
      r_mem_tag <= r_ex_tag;
      r_wb_tag  <= r_mem_tag;
      if (w_issue) begin
        r_ex_tag      <= '{valid: 1'b1, wr_en: id_wr_en, addr: id_wr_addr, is_load: id_is_load};
        output_data_1 <= w_fwd_rs;
        output_data_2 <= w_fwd_rt;
        mux_sel1      <= id_sel_npc;
        mux_sel2      <= id_sel_imm;
        ex_valid      <= 1'b1;
      end else begin
        r_ex_tag      <= c_bubble;
        output_data_1 <= 32'd0;
        output_data_2 <= 32'd0;
        mux_sel1      <= 1'b0;
        mux_sel2      <= 1'b0;
        ex_valid      <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_operand_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exe_operand_issue
//  Purpose  : Directed vector bench for exe_operand_issue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exe_operand_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_rs, id_use_rt, id_sel_npc, id_sel_imm;
  logic        id_wr_en, id_is_load, flush;
  logic [4:0]  id_rs, id_rt, id_wr_addr;
  logic [31:0] rf_rdata1, rf_rdata2, alu_output, mem_fwd_data, wb_fwd_data;
  logic [31:0] output_data_1, output_data_2;
  logic        mux_sel1, mux_sel2, ex_valid, stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exe_operand_issue dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_sel_npc(id_sel_npc),
    .id_sel_imm(id_sel_imm), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
    .id_is_load(id_is_load), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_output(alu_output), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .flush(flush), .output_data_1(output_data_1), .output_data_2(output_data_2),
    .mux_sel1(mux_sel1), .mux_sel2(mux_sel2), .ex_valid(ex_valid), .stall(stall)
  );

  // ctl = {valid, use_rs, use_rt, sel_npc, sel_imm, wr_en, is_load, flush}
  // xctl = {stall, mux_sel1, mux_sel2, ex_valid}
  typedef struct {
    logic [7:0]  ctl;
    logic [4:0]  rs, rt, wa;
    logic [31:0] rf1, rf2, alu, mem, wb;
    logic [3:0]  xctl;
    logic [31:0] xd1, xd2;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {id_valid, id_use_rs, id_use_rt, id_sel_npc, id_sel_imm, id_wr_en, id_is_load, flush} = v.ctl;
    id_rs = v.rs; id_rt = v.rt; id_wr_addr = v.wa;
    rf_rdata1 = v.rf1; rf_rdata2 = v.rf2;
    alu_output = v.alu; mem_fwd_data = v.mem; wb_fwd_data = v.wb;
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] d1, input logic [31:0] d2,
                          input logic s1, input logic s2, input logic ev);
    chk({tag, ".data1"}, output_data_1, d1);
    chk({tag, ".data2"}, output_data_2, d2);
    chk({tag, ".sel1"},  {31'd0, mux_sel1}, {31'd0, s1});
    chk({tag, ".sel2"},  {31'd0, mux_sel2}, {31'd0, s2});
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, ev});
  endtask

  initial begin
    //            ctl          rs     rt     wa     rf1         rf2         alu           mem         wb          xctl     xd1           xd2
    vecs[0]  = '{8'b11100100, 5'd1,  5'd2,  5'd3,  32'h11,     32'h22,     32'h0,        32'h0,      32'h0,      4'b0001, 32'h11,       32'h22};
    vecs[1]  = '{8'b11100100, 5'd3,  5'd4,  5'd6,  32'hAAAA,   32'h44,     32'h1234,     32'h0,      32'h0,      4'b0001, 32'h1234,     32'h44};
    vecs[2]  = '{8'b11100000, 5'd3,  5'd6,  5'd6,  32'hBB,     32'hCC,     32'h5555,     32'h3333,   32'h0,      4'b0001, 32'h3333,     32'h5555};
    vecs[3]  = '{8'b11110110, 5'd3,  5'd6,  5'd5,  32'hD1,     32'hD2,     32'h9999,     32'h8888,   32'h7777,   4'b0101, 32'h7777,     32'h8888};
    vecs[4]  = '{8'b11101100, 5'd1,  5'd5,  5'd8,  32'h101,    32'h102,    32'hDEAD,     32'h0,      32'h0,      4'b1000, 32'h0,        32'h0};
    vecs[5]  = '{8'b11101100, 5'd1,  5'd5,  5'd8,  32'h101,    32'h102,    32'hDEAD,     32'hCAFE,   32'h0,      4'b0011, 32'h101,      32'hCAFE};
    vecs[6]  = '{8'b11100100, 5'd8,  5'd8,  5'd7,  32'h1,      32'h2,      32'h88880000, 32'h0,      32'h0,      4'b0001, 32'h88880000, 32'h88880000};
    vecs[7]  = '{8'b11100100, 5'd8,  5'd0,  5'd7,  32'h3,      32'hF,      32'h0,        32'hB2B2,   32'h0,      4'b0001, 32'hB2B2,     32'hF};
    vecs[8]  = '{8'b11100100, 5'd7,  5'd8,  5'd0,  32'h1,      32'h2,      32'hA1A1,     32'hB2B2,   32'hC3C3,   4'b0001, 32'hA1A1,     32'hC3C3};
    vecs[9]  = '{8'b11100110, 5'd0,  5'd7,  5'd9,  32'h0,      32'h3,      32'hFFFF,     32'hEEEE,   32'hDDDD,   4'b0001, 32'h0,        32'hEEEE};
    vecs[10] = '{8'b11111001, 5'd9,  5'd9,  5'd0,  32'h5,      32'h6,      32'h77,       32'h0,      32'h0,      4'b0000, 32'h0,        32'h0};
    vecs[11] = '{8'b01100000, 5'd9,  5'd9,  5'd0,  32'h5,      32'h6,      32'h0,        32'h0,      32'h0,      4'b0000, 32'h0,        32'h0};
    vecs[12] = '{8'b11000110, 5'd9,  5'd9,  5'd10, 32'h5,      32'h6,      32'h0,        32'h0,      32'h4242,   4'b0001, 32'h4242,     32'h4242};
    vecs[13] = '{8'b10000000, 5'd10, 5'd10, 5'd0,  32'h61,     32'h62,     32'hBEEF,     32'h0,      32'h0,      4'b0001, 32'h61,       32'h62};

    drive('{8'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0});
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    for (int i = 0; i < 14; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(vecs[i]);
      #1;
      chk({tag, ".stall"}, {31'd0, stall}, {31'd0, vecs[i].xctl[3]});
      @(posedge clk);
      #1;
      chk_outs(tag, vecs[i].xd1, vecs[i].xd2, vecs[i].xctl[2], vecs[i].xctl[1], vecs[i].xctl[0]);
      @(negedge clk);
    end

    // Reset asserted while a load-use stall is pending.
    drive('{8'b10000110, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0});
    @(posedge clk);
    @(negedge clk);
    drive('{8'b11000100, 5'd5, 5'd1, 5'd4, 32'h77, 32'h78, 32'h0, 32'h99, 32'h0, 4'b0, 32'h0, 32'h0});
    #1;
    chk("rst_stall.pre", {31'd0, stall}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_outs("rst_stall", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_stall.stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("post_rst.stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    chk_outs("post_rst", 32'h77, 32'h78, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exe_operand_issue.md
EXE_OPERAND_ISSUE -- requirements
Module: exe_operand_issue

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock; sole clock.
REQ-002 SHALL: rst_n  input  1  reset; synchronous, active-high (asserted when 1), sampled on rising clk.
REQ-003 SHALL: id_valid  input  1  ID stage holds a valid instruction.
REQ-004 SHALL: id_rs, id_rt  input  5 each  source register numbers.
REQ-005 SHALL: id_use_rs, id_use_rt  input  1 each  instruction reads rs / rt.
REQ-006 SHALL: id_sel_npc  input  1  EX operand 1 is npc_addr, not rs.
REQ-007 SHALL: id_sel_imm  input  1  EX operand 2 is ex_data, not rt.
REQ-008 SHALL: id_wr_en, id_wr_addr(5), id_is_load  input  destination info of ID instruction.
REQ-009 SHALL: rf_rdata1, rf_rdata2  input  32 each  register-file read data for rs / rt.
REQ-010 SHALL: alu_output  input  32  current EX-stage result.
REQ-011 SHALL: mem_fwd_data, wb_fwd_data  input  32 each  MEM / WB stage results.
REQ-012 SHALL: flush  input  1  squash the ID instruction (branch taken).
REQ-013 SHALL: output_data_1, output_data_2  output  32 each  registered rs / rt operands to EX.
REQ-014 SHALL: mux_sel1, mux_sel2  output  1 each  registered EX operand selects (1 = npc_addr / ex_data).
REQ-015 SHALL: ex_valid  output  1  registered; EX stage holds a valid instruction.
REQ-016 SHALL: stall  output  1  combinational; hold PC and IF/ID this cycle.

Function
REQ-017 SHALL: keep three internal tag stages EX, MEM, WB, each {valid, wr_en, addr[4:0], is_load}; advance EX->MEM->WB every cycle, never stalled.
REQ-018 SHALL: load EX tag from ID fields when issuing; load a zero (bubble) tag otherwise.
REQ-019 SHALL: issue = id_valid & ~stall & ~flush.
REQ-020 SHALL: stall = id_valid & ~flush & EX.valid & EX.is_load & EX.wr_en & EX.addr != 0 & ((id_use_rs & id_rs == EX.addr) | (id_use_rt & id_rt == EX.addr)).
REQ-021 SHALL: forward per source, priority EX (alu_output, only if not load) > MEM (mem_fwd_data) > WB (wb_fwd_data) > regfile; a stage matches only if valid & wr_en & addr == src & addr != 0.
REQ-022 SHALL: register 0 always reads rf_rdata value, never forwarded.
REQ-023 SHALL: on issue, register forwarded rs -> output_data_1, forwarded rt -> output_data_2, id_sel_npc -> mux_sel1, id_sel_imm -> mux_sel2, ex_valid <= 1; latency 1 cycle ID->EX.
REQ-024 SHALL: on non-issue (stall, flush, or ~id_valid) clear output_data_1/2, mux_sel1/2, ex_valid to 0.
REQ-025 SHALL: stall lasts exactly one cycle per load-use hazard; next cycle the load sits in MEM and forwards via mem_fwd_data.
REQ-026 SHALL: flush overrides stall; stall SHALL be 0 when flush = 1.
REQ-027 SHALL: when both sources match the same stage, forward to both.
REQ-028 SHALL: data widths fixed 32 bits; no arithmetic performed.

Reset
REQ-029 SHALL: while rst_n = 1 at a clock edge, clear all tag stages, output_data_1/2, mux_sel1/2, ex_valid to 0; stall reads 0 the cycle after.
REQ-030 SHALL: reset mid-stall discards the pending instruction; no issue on the reset cycle.

Verification
REQ-031 SHALL: EX=add r3, ID uses rs=r3, alu_output=0x1234 -> next cycle output_data_1=0x1234, ex_valid=1.
REQ-032 SHALL: EX=lw r5, ID rt=r5, id_use_rt=1 -> stall=1 one cycle, ex_valid=0 next; then issue with output_data_2=mem_fwd_data (0xCAFE).
REQ-033 SHALL: EX and MEM both write r7, ID rs=r7 -> EX value (alu_output) chosen, not mem_fwd_data.
REQ-034 SHALL: EX writes r0, ID rs=r0, rf_rdata1=0 -> output_data_1=0.
REQ-035 SHALL: ID id_sel_npc=1, id_sel_imm=1 with flush=1 -> stall=0, next cycle all outputs 0.
REQ-036 SHALL: rst_n=1 during a load-use stall -> next cycle all outputs 0, stall=0, tags empty.
